rptr_empty_lvl: RTL and testbench

Read-side pointer and status block for the dual-clock FIFO. It is the parametrised successor of the basic read-pointer/empty generator. Beyond binary and Gray read pointers and a registered empty flag, it adds:
- read-domain fill level
- programmable almost-empty flag
- underflow pulse
- selectable RAM address timing
It sits in the read clock domain. It consumes the write Gray pointer already synchronised into that domain, and drives the RAM read address plus the Gray read pointer sent to the write-side synchroniser.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/gray2bin_dec.sv | 15 +
 rtl/rptr_empty_lvl.sv | 109 ++++++++++
 tb/tb_rptr_empty_lvl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer blocks: RAM address
// timing selectors and Gray-code helpers used by both read and write sides.
package fifo_pkg;

    // rd_addr timing: current registered pointer, or look-ahead next pointer
    localparam int ADDR_MODE_CUR  = 0;
    localparam int ADDR_MODE_NEXT = 1;

    // Widest pointer the helpers below handle. Narrower pointers are passed
    // zero-extended and the result is cut back to the caller's width.
    localparam int FIFO_MAX_W = 32;

    // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
    function automatic logic [FIFO_MAX_W-1:0] bin2gray(input logic [FIFO_MAX_W-1:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

    // Gray to binary: XOR prefix running down from the MSB. Zero-extended
    // upper bits leave the low bits untouched, so one function serves every width.
    function automatic logic [FIFO_MAX_W-1:0] gray2bin(input logic [FIFO_MAX_W-1:0] i_gray);
        logic [FIFO_MAX_W-1:0] v_bin;
        // NOTE: blocking assignments are correct here; each bit depends on the
        // one just computed above it within the same evaluation.
        v_bin[FIFO_MAX_W-1] = i_gray[FIFO_MAX_W-1];
        for (int i = FIFO_MAX_W - 2; i >= 0; i--) begin
            v_bin[i] = v_bin[i+1] ^ i_gray[i];
        end
        return v_bin;
    endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// Combinational Gray-to-binary decoder of configurable width. Shared by the
// read-side empty/level block and the write-side full block.
module gray2bin_dec
    import fifo_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // Decode through the shared package helper; WIDTH must not exceed FIFO_MAX_W.
    assign o_bin = WIDTH'(gray2bin(FIFO_MAX_W'(i_gray)));

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-side pointer and status block of the dual-clock FIFO. Keeps binary and
// Gray read pointers, a registered empty flag, the read-side fill level, an
// almost-empty flag, an underflow pulse, and drives the RAM read address.
// Everything here runs on clk_rd; the write pointer arrives already
// synchronised into this domain, so flags only ever lag writes, never reads.
module rptr_empty_lvl
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = 4,
    parameter int ADDR_MODE = ADDR_MODE_CUR
) (
    input  logic                 clk_rd,
    input  logic                 rst_rd,
    input  logic                 rd_en,
    input  logic [PTR_WIDTH:0]   wr_gray_sync_rd,
    input  logic [PTR_WIDTH:0]   ae_level,
    output logic [PTR_WIDTH-1:0] rd_addr,
    output logic [PTR_WIDTH:0]   rd_gray,
    output logic                 rd_empty,
    output logic                 rd_almost_empty,
    output logic [PTR_WIDTH:0]   rd_level,
    output logic                 rd_underflow
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PW1 = PTR_WIDTH + 1;

    logic [PTR_WIDTH:0] r_bin;
    logic [PTR_WIDTH:0] r_gray;
    logic [PTR_WIDTH:0] r_level;
    logic               r_empty;
    logic               r_almost_empty;
    logic               r_underflow;

    logic               w_pop;
    logic [PTR_WIDTH:0] w_bin_next;
    logic [PTR_WIDTH:0] w_gray_next;
    logic [PTR_WIDTH:0] w_wbin;
    logic [PTR_WIDTH:0] w_level_next;
    logic               w_empty_next;
    logic               w_almost_empty_next;

    // Decode the synchronised write pointer; it may have jumped several
    // steps since the last edge, the level simply follows the decoded value.
    gray2bin_dec #(
        .WIDTH (PW1)
    ) u_wr_dec (
        .i_gray (wr_gray_sync_rd),
        .o_bin  (w_wbin)
    );

    // A read is honoured only when the FIFO is not empty; a read attempted
    // while empty leaves the pointer where it is.
    assign w_pop      = rd_en & ~r_empty;
    assign w_bin_next = r_bin + {{PTR_WIDTH{1'b0}}, w_pop};
    assign w_gray_next = PW1'(bin2gray(FIFO_MAX_W'(w_bin_next)));

    // Next-state status from the next pointer, so popping the last word flags
    // empty on the very next edge with no bubble. Modulo subtraction keeps
    // the level correct across pointer wrap; a same-cycle pop and write
    // cancel naturally.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_level_next        = '0;
        w_empty_next        = 1'b1;
        w_almost_empty_next = 1'b1;

        w_level_next        = w_wbin - w_bin_next;
        w_empty_next        = (w_gray_next == wr_gray_sync_rd);
        w_almost_empty_next = (w_level_next <= ae_level);
    end

    // Pointer and status registers; reset discards the pointer position at once.
    always_ff @(posedge clk_rd or posedge rst_rd) begin
        if (rst_rd) begin
            r_bin          <= '0;
            r_gray         <= '0;
            r_level        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_underflow    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_bin          <= w_bin_next;
            r_gray         <= w_gray_next;
            r_level        <= w_level_next;
            r_empty        <= w_empty_next;
            r_almost_empty <= w_almost_empty_next;
            r_underflow    <= rd_en & r_empty;
        end
    end

    // RAM address: current word for asynchronous-read RAM, or the next pointer
    // so a synchronous-read RAM has its data ready one edge later.
    if (ADDR_MODE == ADDR_MODE_NEXT) begin : g_addr_next
        assign rd_addr = w_bin_next[PTR_WIDTH-1:0];
    end else begin : g_addr_cur
        assign rd_addr = r_bin[PTR_WIDTH-1:0];
    end

    assign rd_gray         = r_gray;
    assign rd_empty        = r_empty;
    assign rd_almost_empty = r_almost_empty;
    assign rd_level        = r_level;
    assign rd_underflow    = r_underflow;

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed bench for rptr_empty_lvl at PTR_WIDTH=3. Two instances share all
// inputs: dut0 uses current-pointer addressing, dut1 look-ahead addressing.
// Each clocked step pushes its expected outcome to a scoreboard queue and
// pops it for comparison one time unit after the next rising edge.
module tb_rptr_empty_lvl;

    localparam int PW = 3;
    localparam int W1 = PW + 1;

    logic          clk_rd = 1'b0;
    logic          rst_rd;
    logic          rd_en;
    logic [W1-1:0] wr_gray_sync_rd;
    logic [W1-1:0] ae_level;

    logic [PW-1:0] addr0, addr1;
    logic [W1-1:0] gray0, gray1, level0, level1;
    logic          empty0, empty1, ae0, ae1, uf0, uf1;

    rptr_empty_lvl #(.PTR_WIDTH(PW), .ADDR_MODE(0)) dut0 (
        .clk_rd          (clk_rd),
        .rst_rd          (rst_rd),
        .rd_en           (rd_en),
        .wr_gray_sync_rd (wr_gray_sync_rd),
        .ae_level        (ae_level),
        .rd_addr         (addr0),
        .rd_gray         (gray0),
        .rd_empty        (empty0),
        .rd_almost_empty (ae0),
        .rd_level        (level0),
        .rd_underflow    (uf0)
    );

    rptr_empty_lvl #(.PTR_WIDTH(PW), .ADDR_MODE(1)) dut1 (
        .clk_rd          (clk_rd),
        .rst_rd          (rst_rd),
        .rd_en           (rd_en),
        .wr_gray_sync_rd (wr_gray_sync_rd),
        .ae_level        (ae_level),
        .rd_addr         (addr1),
        .rd_gray         (gray1),
        .rd_empty        (empty1),
        .rd_almost_empty (ae1),
        .rd_level        (level1),
        .rd_underflow    (uf1)
    );

    always #5 clk_rd = ~clk_rd;

    typedef struct {
        logic [W1-1:0] gray;
        logic [PW-1:0] addr;
        logic          empty;
        logic          ae;
        logic [W1-1:0] level;
        logic          uf;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference read pointer and empty state
    logic [W1-1:0] m_bin;
    logic          m_empty;

    function automatic logic [W1-1:0] b2g(input logic [W1-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W1-1:0] g2b(input logic [W1-1:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_empty"}, 32'(empty0), 32'd1);
        check({tag, "_ae"},    32'(ae0),    32'd1);
        check({tag, "_level"}, 32'(level0), 32'd0);
        check({tag, "_gray"},  32'(gray0),  32'd0);
        check({tag, "_addr0"}, 32'(addr0),  32'd0);
        check({tag, "_addr1"}, 32'(addr1),  32'd0);
        check({tag, "_uf"},    32'(uf0),    32'd0);
    endtask

    // One read-clock cycle: drive on the falling edge, predict, compare after the rise
    task automatic step(input logic en, input logic [W1-1:0] wg);
        exp_t          e;
        exp_t          got;
        logic          pop;
        logic [W1-1:0] bn;
        @(negedge clk_rd);
        rd_en           = en;
        wr_gray_sync_rd = wg;
        pop     = en & ~m_empty;
        bn      = m_bin + W1'(pop);
        e.gray  = b2g(bn);
        e.addr  = bn[PW-1:0];
        e.empty = (b2g(bn) == wg);
        e.level = g2b(wg) - bn;
        e.ae    = (e.level <= ae_level);
        e.uf    = en & m_empty;
        sb_q.push_back(e);
        #1;
        check("addr_lookahead_pre", 32'(addr1), 32'(bn[PW-1:0]));
        check("addr_current_pre",   32'(addr0), 32'(m_bin[PW-1:0]));
        @(posedge clk_rd);
        #1;
        got = sb_q.pop_front();
        check("gray",   32'(gray0),  32'(got.gray));
        check("addr",   32'(addr0),  32'(got.addr));
        check("empty",  32'(empty0), 32'(got.empty));
        check("ae",     32'(ae0),    32'(got.ae));
        check("level",  32'(level0), 32'(got.level));
        check("uf",     32'(uf0),    32'(got.uf));
        check("level_la", 32'(level1), 32'(got.level));
        check("empty_la", 32'(empty1), 32'(got.empty));
        m_bin   = bn;
        m_empty = got.empty;
    endtask

    // Asynchronous reset pulse away from the rising edge
    task automatic async_reset(input string tag);
        @(negedge clk_rd);
        #2;
        rst_rd          = 1'b1;
        rd_en           = 1'b0;
        wr_gray_sync_rd = '0;
        #1;
        check_reset(tag);
        @(negedge clk_rd);
        rst_rd  = 1'b0;
        m_bin   = '0;
        m_empty = 1'b1;
    endtask

    initial begin
        rst_rd          = 1'b0;
        rd_en           = 1'b0;
        wr_gray_sync_rd = '0;
        ae_level        = 4'd1;
        m_bin           = '0;
        m_empty         = 1'b1;

        // Reset state
        #1 rst_rd = 1'b1;
        #2;
        check_reset("reset");
        @(negedge clk_rd);
        rst_rd = 1'b0;

        // Fill to 3 words, then drain
        step(1'b0, 4'b0010);
        check("fill_level3", 32'(level0), 32'd3);
        check("fill_empty0", 32'(empty0), 32'd0);
        check("fill_ae0",    32'(ae0),    32'd0);
        step(1'b1, 4'b0010);
        step(1'b1, 4'b0010);
        check("drain_gray",  32'(gray0),  32'b0011);
        check("drain_level", 32'(level0), 32'd1);
        check("drain_ae1",   32'(ae0),    32'd1);
        step(1'b1, 4'b0010);
        check("last_pop_empty", 32'(empty0), 32'd1);
        check("last_pop_level", 32'(level0), 32'd0);

        // Underflow: one-cycle pulse, pointer frozen
        step(1'b1, 4'b0010);
        check("uf_pulse",  32'(uf0),   32'd1);
        check("uf_gray",   32'(gray0), 32'b0010);
        check("uf_addr",   32'(addr0), 32'd3);
        step(1'b0, 4'b0010);
        check("uf_cleared", 32'(uf0),  32'd0);

        // Mid-traffic reset with two words outstanding
        step(1'b0, 4'b0111);
        async_reset("mid_reset");

        // Full FIFO and pointer wrap over 16 pops
        step(1'b0, 4'b1100);
        check("full_level8", 32'(level0), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b1, 4'b1100);
        check("wrap8_gray",  32'(gray0),  32'b1100);
        check("wrap8_addr",  32'(addr0),  32'd0);
        check("wrap8_empty", 32'(empty0), 32'd1);
        step(1'b0, 4'b0000);
        check("refill_level8", 32'(level0), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b1, 4'b0000);
        check("wrap16_gray",  32'(gray0),  32'b0000);
        check("wrap16_empty", 32'(empty0), 32'd1);

        // Concurrent pop and write: rd_bin=5, write pointer 6 -> 7
        step(1'b0, 4'b0101);
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0101);
        check("conc_pre_level", 32'(level0), 32'd1);
        step(1'b1, 4'b0100);
        check("conc_level", 32'(level0), 32'd1);
        check("conc_empty", 32'(empty0), 32'd0);

        // Almost-empty thresholds at the extremes
        ae_level = 4'd0;
        step(1'b0, 4'b0100);
        check("ae0_tracks_empty", 32'(ae0), 32'(empty0));
        ae_level = 4'd8;
        step(1'b0, 4'b0100);
        check("ae8_held", 32'(ae0), 32'd1);
        ae_level = 4'd1;

        // Look-ahead address timing
        async_reset("pre_la_reset");
        step(1'b0, 4'b0110);
        step(1'b1, 4'b0110);
        step(1'b1, 4'b0110);
        @(negedge clk_rd);
        rd_en = 1'b1;
        #1;
        check("la_addr_pop",  32'(addr1), 32'd3);
        rd_en = 1'b0;
        #1;
        check("la_addr_idle", 32'(addr1), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
